// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage: MIPS opcode/funct encodings,
// register file geometry and the write-data source selector.
package wb_regfile_pkg;

    localparam int DATA_W = 32;
    localparam int REG_N  = 32;
    localparam int ADDR_W = $clog2(REG_N);

    localparam logic [ADDR_W-1:0] REG_RA = 5'd31;

    // Primary opcodes, ir[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;

    // SPECIAL funct codes, ir[5:0]
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_ALU  = 3'd1,
        SRC_MEM  = 3'd2,
        SRC_MD   = 3'd3,
        SRC_PC8  = 3'd4
    } wb_src_e;

endpackage

// File: rtl/wb_decode.sv
// Combinational W-stage decode: instruction -> write request, destination, data source.
// Zero latency; a bubble (all-zero word) decodes as sll and therefore never writes.
import wb_regfile_pkg::*;

module wb_decode (
    input  logic [31:0]       ir,
    output logic              we,
    output logic [ADDR_W-1:0] dest,
    output logic [2:0]        src
);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic              unused_ir;

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign unused_ir = ^{ir[25:21], ir[10:6]};

    always_comb begin
        we   = 1'b0;
        dest = '0;
        src  = SRC_NONE;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLTU: begin
                        we   = 1'b1;
                        dest = rd;
                        src  = SRC_ALU;
                    end
                    F_MFHI, F_MFLO: begin
                        we   = 1'b1;
                        dest = rd;
                        src  = SRC_MD;
                    end
                    default: ;
                endcase
            end
            OP_LUI, OP_ADDI, OP_ANDI, OP_ORI: begin
                we   = 1'b1;
                dest = rt;
                src  = SRC_ALU;
            end
            OP_LW, OP_LH, OP_LB: begin
                we   = 1'b1;
                dest = rt;
                src  = SRC_MEM;
            end
            OP_JAL: begin
                we   = 1'b1;
                dest = REG_RA;
                src  = SRC_PC8;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage + 32x32 GPR file; W outputs are same-cycle, commits land one edge later.
// Define GRF_BYPASS_EN to have read ports return the in-flight W write data.
import wb_regfile_pkg::*;

module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_ir,
    input  logic [31:0] wb_rd,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_pc_8,
    input  logic [31:0] wb_alu_out,
    input  logic [31:0] wb_muldiv_out,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic [31:0] retire_count
);

    logic [DATA_W-1:0] regs [REG_N];
    logic              dec_we;
    logic [ADDR_W-1:0] dec_dest;
    logic [2:0]        dec_src;
    logic [DATA_W-1:0] sel_data;
    logic              unused_pc;

    // PC is carried for trace visibility only.
    assign unused_pc = ^wb_pc;

    wb_decode u_decode (
        .ir   (wb_ir),
        .we   (dec_we),
        .dest (dec_dest),
        .src  (dec_src)
    );

    always_comb begin
        case (dec_src)
            SRC_ALU: sel_data = wb_alu_out;
            SRC_MEM: sel_data = wb_rd;
            SRC_MD:  sel_data = wb_muldiv_out;
            SRC_PC8: sel_data = wb_pc_8;
            default: sel_data = '0;
        endcase
    end

    always_comb begin
        wb_we    = dec_we && (dec_dest != '0) && !reset;
        wb_waddr = wb_we ? dec_dest : '0;
        wb_wdata = wb_we ? sel_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count <= '0;
        end else if (wb_ir != '0) begin
            retire_count <= retire_count + 32'd1;
        end
    end

`ifdef GRF_BYPASS_EN
    // Write-then-read: a port matching the live W destination sees the new value now.
    always_comb begin
        if (rs_addr == '0)
            rs_data = '0;
        else if (wb_we && (rs_addr == wb_waddr))
            rs_data = wb_wdata;
        else
            rs_data = regs[rs_addr];

        if (rt_addr == '0)
            rt_data = '0;
        else if (wb_we && (rt_addr == wb_waddr))
            rt_data = wb_wdata;
        else
            rt_data = regs[rt_addr];
    end
`else
    // Stored value only; the hazard unit forwards from W.
    always_comb begin
        rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
        rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expected W/read/count values, monitor compares at negedge.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] wb_ir, wb_rd, wb_pc, wb_pc_8, wb_alu_out, wb_muldiv_out;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [31:0] retire_count;

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .wb_ir         (wb_ir),
        .wb_rd         (wb_rd),
        .wb_pc         (wb_pc),
        .wb_pc_8       (wb_pc_8),
        .wb_alu_out    (wb_alu_out),
        .wb_muldiv_out (wb_muldiv_out),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_we         (wb_we),
        .wb_waddr      (wb_waddr),
        .wb_wdata      (wb_wdata),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef GRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Instruction classes known to the generator; the model never decodes bits.
    localparam int K_RALU = 0, K_MD = 1, K_IALU = 2, K_LOAD = 3, K_JAL = 4, K_NOWR = 5, K_BUB = 6;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("wb_we",        {31'b0, wb_we}, {31'b0, e.we});
            chk("wb_waddr",     {27'b0, wb_waddr}, {27'b0, e.wa});
            chk("wb_wdata",     wb_wdata, e.wd);
            chk("rs_data",      rs_data, e.rs);
            chk("rt_data",      rt_data, e.rt);
            chk("retire_count", retire_count, e.cnt);
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic w,
                                               input logic [4:0] d, input logic [31:0] v);
        if (a == 5'd0) return 32'd0;
        if (BYP && w && a == d) return v;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] gen(input int kind);
        logic [4:0]  s, t, d;
        logic [15:0] imm;
        logic [5:0]  f, op;
        logic [31:0] r;
        s = 5'($urandom); t = 5'($urandom); d = 5'($urandom); imm = 16'($urandom);
        f = 6'h00; op = 6'h00; r = 32'd0;
        case (kind)
            K_RALU: begin
                case ($urandom_range(0, 5))
                    0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24;
                    3: f = 6'h25; 4: f = 6'h2A; default: f = 6'h2B;
                endcase
                r = {6'h00, s, t, d, 5'h00, f};
            end
            K_MD: r = {6'h00, 10'h000, d, 5'h00, ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12};
            K_IALU: begin
                case ($urandom_range(0, 3))
                    0: op = 6'h0F; 1: op = 6'h08; 2: op = 6'h0C; default: op = 6'h0D;
                endcase
                r = {op, s, t, imm};
            end
            K_LOAD: begin
                case ($urandom_range(0, 2))
                    0: op = 6'h23; 1: op = 6'h21; default: op = 6'h20;
                endcase
                r = {op, s, t, imm};
            end
            K_JAL: r = {6'h03, 26'($urandom)};
            K_NOWR: begin
                case ($urandom_range(0, 7))
                    0: r = {6'h2B, s, t, imm};
                    1: r = {6'h04, s, t, imm};
                    2: r = {6'h00, s, 15'h0000, 6'h08};
                    3: r = {6'h00, s, t, 10'h000, 6'h18};
                    4: r = {6'h00, s, t, 10'h000, 6'h1A};
                    5: r = {6'h00, s, 15'h0000, 6'h11};
                    6: r = {6'h00, s, 15'h0000, 6'h13};
                    default: r = {6'h29, s, t, imm};
                endcase
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Called #1 after a posedge; applies one W-stage cycle and leaves #1 after the next posedge.
    task automatic drive(input int kind, input logic rst, input logic [31:0] ir,
                         input logic [31:0] rd_v, input logic [31:0] pc8, input logic [31:0] alu,
                         input logic [31:0] md, input logic [4:0] ra, input logic [4:0] rb);
        exp_t        e;
        logic        w;
        logic [4:0]  d;
        logic [31:0] v;
        reset = rst; wb_ir = ir; wb_rd = rd_v; wb_pc = $urandom; wb_pc_8 = pc8;
        wb_alu_out = alu; wb_muldiv_out = md; rs_addr = ra; rt_addr = rb;
        w = 1'b1;
        case (kind)
            K_RALU:  begin d = ir[15:11]; v = alu;  end
            K_MD:    begin d = ir[15:11]; v = md;   end
            K_IALU:  begin d = ir[20:16]; v = alu;  end
            K_LOAD:  begin d = ir[20:16]; v = rd_v; end
            K_JAL:   begin d = 5'd31;     v = pc8;  end
            default: begin d = 5'd0;      v = 32'd0; w = 1'b0; end
        endcase
        if (rst || d == 5'd0) w = 1'b0;
        e.we  = w;
        e.wa  = w ? d : 5'd0;
        e.wd  = w ? v : 32'd0;
        e.rs  = model_read(ra, w, d, v);
        e.rt  = model_read(rb, w, d, v);
        e.cnt = m_cnt;
        q.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 32'd0;
        end else begin
            if (w) m_regs[d] = v;
            if (ir != 32'd0) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic drive_rand();
        int   k;
        logic r;
        k = $urandom_range(0, 6);
        r = ($urandom_range(0, 39) == 0);
        drive(k, r, gen(k), $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom));
    endtask

    initial begin
        reset = 1'b1; wb_ir = 32'd0; wb_rd = 32'd0; wb_pc = 32'd0; wb_pc_8 = 32'd0;
        wb_alu_out = 32'd0; wb_muldiv_out = 32'd0; rs_addr = 5'd0; rt_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;

        // Post-reset state
        drive(K_BUB, 1'b0, 32'd0, 0, 0, 0, 0, 5'd5, 5'd31);
        // add $3 = 0x12345678, then read it back
        drive(K_RALU, 1'b0, {6'h00, 5'd1, 5'd2, 5'd3, 5'h00, 6'h20}, 0, 0, 32'h12345678, 0, 5'd0, 5'd0);
        drive(K_BUB, 1'b0, 32'd0, 0, 0, 0, 0, 5'd3, 5'd0);
        // lw $8, same-cycle read then next-cycle read
        drive(K_LOAD, 1'b0, {6'h23, 5'd0, 5'd8, 16'h0004}, 32'hDEADBEEF, 0, 0, 0, 5'd0, 5'd8);
        drive(K_BUB, 1'b0, 32'd0, 0, 0, 0, 0, 5'd8, 5'd8);
        // jal links to $31; ori into $0 must not write
        drive(K_JAL, 1'b0, {6'h03, 26'h0000C00}, 0, 32'h00003008, 0, 0, 5'd31, 5'd31);
        drive(K_IALU, 1'b0, {6'h0D, 5'd1, 5'd0, 16'hFFFF}, 0, 0, 32'h0000FFFF, 0, 5'd0, 5'd31);
        // sw, beq, mult, bubble: no writes, three retirements
        drive(K_NOWR, 1'b0, {6'h2B, 5'd3, 5'd8, 16'h0010}, 0, 0, 32'hAAAA5555, 0, 5'd3, 5'd8);
        drive(K_NOWR, 1'b0, {6'h04, 5'd3, 5'd8, 16'hFFFE}, 0, 0, 32'h11112222, 0, 5'd31, 5'd8);
        drive(K_NOWR, 1'b0, {6'h00, 5'd3, 5'd8, 10'h000, 6'h18}, 0, 0, 32'h33334444, 0, 5'd3, 5'd31);
        drive(K_BUB, 1'b0, 32'd0, 0, 0, 0, 0, 5'd8, 5'd3);
        // mflo $4 while reset: write dropped, count cleared
        drive(K_MD, 1'b1, {6'h00, 10'h000, 5'd4, 5'h00, 6'h12}, 0, 0, 0, 32'h7, 5'd4, 5'd4);
        drive(K_BUB, 1'b0, 32'd0, 0, 0, 0, 0, 5'd4, 5'd31);

        for (int n = 0; n < 400; n++) drive_rand();

        reset = 1'b0; wb_ir = 32'd0;
        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general register file for the five-stage MIPS core. Consumes the MEM/WB pipeline register contents, decodes the retiring instruction, selects write data, and commits it to the 32×32 register file. Serves the two decode-stage read ports and exports the write port so earlier stages can forward from W. Keeps a retired-instruction counter for bench and debug use.

## Interface
- DATA_W, 32, datapath and register width
- REG_N, 32, number of architectural registers (address width log2(REG_N) = 5)

- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- wb_ir  in  32  instruction in W; 0 is a bubble (nop)
- wb_rd  in  32  load data from memory stage, already byte/half extended
- wb_pc  in  32  PC of the instruction in W (trace only)
- wb_pc_8  in  32  PC+8, link value
- wb_alu_out  in  32  ALU result
- wb_muldiv_out  in  32  HI/LO read result
- rs_addr  in  5  decode read port A address
- rt_addr  in  5  decode read port B address
- rs_data  out  32  read port A data
- rt_data  out  32  read port B data
- wb_we  out  1  register write occurs this cycle
- wb_waddr  out  5  destination register (0 when wb_we=0)
- wb_wdata  out  32  write data (0 when wb_we=0)
- retire_count  out  32  count of non-bubble instructions retired

## Operation
- Decode (from wb_ir opcode [31:26], funct [5:0]):
  - opcode 0, funct add/sub/and/or/slt/sltu -> dest rd [15:11], data wb_alu_out
  - opcode 0, funct mfhi/mflo -> dest rd, data wb_muldiv_out
  - lui/addi/andi/ori -> dest rt [20:16], data wb_alu_out
  - lw/lh/lb -> dest rt, data wb_rd
  - jal -> dest 31, data wb_pc_8
  - all others (stores, branches, jr, mult/div, mthi/mtlo, bubble) -> no write
- wb_we = decoded write AND dest != 0 AND NOT reset. Register 0 never written; reads of 0 return 0.
- Commit: on posedge clk with wb_we=1, reg[wb_waddr] <= wb_wdata.
- Reads are combinational from the array (bypass rules under Configuration).
- retire_count increments by 1 on each posedge with reset=0 and wb_ir != 0; wraps 0xFFFFFFFF -> 0.

## Timing
- Reset: all 32 registers -> 0, retire_count -> 0 at the clock edge where reset=1. While reset=1: wb_we=0, wb_waddr=0, wb_wdata=0, no register write, no count. rs_data/rt_data read the array (0 after first reset edge).
- Write latency: value visible in the array one edge after it is presented in W.
- wb_we/wb_waddr/wb_wdata are combinational from W inputs, same cycle.
- Reset asserted while a writing instruction sits in W: write is dropped.
- Both read ports may address the same register, including the one being written; each resolves independently.

## Configuration
- GRF_BYPASS_EN defined: if wb_we=1 and read address == wb_waddr (nonzero), read port returns wb_wdata in the same cycle (write-then-read). Decode stage needs no W-stage forwarding.
- Undefined: read ports return the stored value only; the new value appears the cycle after the write; hazard unit must forward from W.

## Structure
- Shared package: opcode and funct constants (ADD, SUB, AND, OR, SLT, SLTU, MFHI, MFLO, LUI, ADDI, ANDI, ORI, LW, LH, LB, JAL), write-data source enum {SRC_NONE, SRC_ALU, SRC_MEM, SRC_MD, SRC_PC8}, REG_RA = 31.
- One sub-module: wb_decode (combinational: wb_ir -> write enable, destination select, data source). Array, mux, bypass, counter stay in wb_regfile.

## Test plan
- Reset, then read rs_addr=5, rt_addr=31 -> both 0; retire_count=0; wb_we=0.
- addu-class add $3 (rd=3), wb_alu_out=0x12345678 -> wb_we=1, waddr=3; next cycle rs_addr=3 returns 0x12345678; retire_count=1.
- lw rt=8, wb_rd=0xDEADBEEF, same-cycle rt_addr=8 -> 0xDEADBEEF with GRF_BYPASS_EN, prior value (0) without; next cycle 0xDEADBEEF both builds.
- jal, wb_pc_8=0x00003008 -> reg31=0x00003008; ori with rt=0, wb_alu_out=0xFFFF -> wb_we=0, reg0 stays 0.
- sw, beq, mult, and wb_ir=0 in consecutive cycles -> no register changes; retire_count +3 (bubble not counted).
- mflo rd=4 with wb_muldiv_out=0x7 while reset=1 -> reg4 unchanged (0), count 0; preload retire_count path to 0xFFFFFFFF then retire one -> 0.
